nibble_serial_adder: RTL and testbench

- Multi-cycle WIDTH-bit add/subtract unit built around one `cla_4` instance, processing one 4-bit nibble per clock from LSB to MSB.
- Sits directly upstream of `cla_4`: it supplies `cla_4`'s a/b/cin every cycle and consumes its sum/cout, rippling the carry through a register.
- Serves as the area-lean adder path for the datapath ALU, using a start/busy/done handshake.

---
 rtl/nibble_serial_adder.sv | 189 ++++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract unit that reuses one 4-bit carry-lookahead
// adder and processes one nibble per clock, LSB first, with a start/busy/done handshake.

module cla_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   bx_q, bx_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   partial_q, partial_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [IDX_W+1:0]   nib_lsb;
    logic [3:0]         nib_a;
    logic [3:0]         nib_b;
    logic [3:0]         nib_sum;
    logic               nib_cout;
    logic [WIDTH-1:0]   partial_next;
    logic               last_nib;

    assign nib_lsb  = {idx_q, 2'b00};
    assign nib_a    = a_q[nib_lsb +: 4];
    assign nib_b    = bx_q[nib_lsb +: 4];
    assign last_nib = (idx_q == IDX_W'(NIB - 1));

    cla_4 u_cla (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_comb begin
        partial_next                = partial_q;
        partial_next[nib_lsb +: 4] = nib_sum;
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        bx_d      = bx_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        partial_d = partial_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    a_d       = a;
                    bx_d      = sub ? ~b : b;
                    carry_d   = sub ? 1'b1 : cin;
                    idx_d     = '0;
                    partial_d = '0;
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                partial_d = partial_next;
                carry_d   = nib_cout;
                idx_d     = idx_q + IDX_W'(1);
                // The final nibble is folded in here so results appear with done.
                if (last_nib) begin
                    idx_d   = '0;
                    sum_d   = partial_next;
                    cout_d  = nib_cout;
                    ovf_d   = (a_q[WIDTH-1] == bx_q[WIDTH-1])
                              && (partial_next[WIDTH-1] != a_q[WIDTH-1]);
                    zero_d  = (partial_next == '0);
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            bx_q      <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            partial_q <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            bx_q      <= bx_d;
            carry_q   <= carry_d;
            idx_q     <= idx_d;
            partial_q <= partial_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            zero_q    <= zero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: accepts are observed at the clock edge
// and queue a hand-computed result; a monitor compares each done pulse against it.

module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
        logic [31:0]      acc;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    exp_t             pending;
    exp_t             sb_q[$];
    logic [18:0]      held;
    int unsigned      cyc_cnt;
    int               checks;
    int               errors;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
        end
    endtask

    // Accept detector: busy is read before the DUT's nonblocking update.
    always @(posedge clk) begin
        cyc_cnt++;
        if (rst_n && start && !busy) begin
            exp_t e;
            e     = pending;
            e.acc = cyc_cnt;
            sb_q.push_back(e);
        end
    end

    always @(negedge rst_n) begin
        sb_q.delete();
        held = '0;
    end

    // Monitor: compares on done, otherwise results must hold their last value.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    checkOutput("sum",     32'(sum),  32'(e.sum));
                    checkOutput("cout",    32'(cout), 32'(e.cout));
                    checkOutput("ovf",     32'(ovf),  32'(e.ovf));
                    checkOutput("zero",    32'(zero), 32'(e.zero));
                    checkOutput("latency", cyc_cnt - e.acc, 32'(NIB));
                    held = {e.sum, e.cout, e.ovf, e.zero};
                end
            end else begin
                checkOutput("hold_stable", 32'({sum, cout, ovf, zero}), 32'(held));
            end
        end
    end

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput({name, "_idle_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                 input logic vcin, input logic vsub,
                                 input logic [WIDTH-1:0] esum, input logic ecout,
                                 input logic eovf);
        waitIdle("apply");
        @(negedge clk);
        a            = va;
        b            = vb;
        cin          = vcin;
        sub          = vsub;
        pending.sum  = esum;
        pending.cout = ecout;
        pending.ovf  = eovf;
        pending.zero = (esum == '0);
        pending.acc  = '0;
        start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int n;
        checks  = 0;
        errors  = 0;
        cyc_cnt = 0;
        held    = '0;
        pending = '0;
        rst_n   = 1'b0;
        start   = 1'b0;
        sub     = 1'b0;
        a       = '0;
        b       = '0;
        cin     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_sum",  32'(sum),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add, with busy-duration check from the negedge after the accept edge.
        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        n = 0;
        while (busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        checkOutput("busy_cycles", 32'(n), 32'(NIB + 1));

        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus(16'hFFFE, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        applyStimulus(16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Held start: operands change while busy; the next IDLE edge takes the new ones.
        waitIdle("held");
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
        pending.sum = 16'h3333; pending.cout = 1'b0; pending.ovf = 1'b0; pending.zero = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555;
        pending.sum = 16'hFFFF; pending.cout = 1'b0; pending.ovf = 1'b0; pending.zero = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;

        // Reset after two nibble edges: in-flight result must be discarded.
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_sum",  32'(sum),  32'd0);
        checkOutput("rst_flags", 32'({cout, ovf, zero}), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (NIB + 3) @(negedge clk);
        checkOutput("no_done_after_reset", 32'(sb_q.size()), 32'd0);

        applyStimulus(16'h0100, 16'h0F00, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

        n = 0;
        while ((busy || sb_q.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_queue", 32'(sb_q.size()), 32'd0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
